i2s_dac_tx: RTL

- Serialises stereo PCM sample pairs onto the WM8731 DAC interface in I2S format: AUD_BCLK, AUD_DACLRCK, AUD_DACDAT.
- Generates all interface clocks itself from CLOCK_50.
- Sits directly downstream of the audio sample fetch/ROM stage and fetches one L/R pair per frame through a valid/ready handshake.
- Runs alongside the I2C codec configuration logic, which has already put the codec into I2S slave mode.

---
 rtl/i2s_dac_tx_if.sv | 20 ++
 rtl/i2s_dac_tx.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/i2s_dac_tx_if.sv
// Upstream sample handshake between the sample fetch stage and i2s_dac_tx.
// One stereo pair moves per SAMPLE_VALID && SAMPLE_READY cycle.
interface i2s_dac_tx_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] SAMPLE_L;
    logic [WIDTH-1:0] SAMPLE_R;
    logic             SAMPLE_VALID;
    logic             SAMPLE_READY;

    modport master (
        output SAMPLE_L, SAMPLE_R, SAMPLE_VALID,
        input  SAMPLE_READY
    );

    modport slave (
        input  SAMPLE_L, SAMPLE_R, SAMPLE_VALID,
        output SAMPLE_READY
    );
endinterface

// File: rtl/i2s_dac_tx.sv
// I2S serialiser for the WM8731 DAC: derives BCLK/LRCK from CLOCK_50, buffers one L/R pair, counts underruns.
// Optional macro I2S_TX_HOLD_LAST_EN: underrun frames repeat the last transmitted pair instead of zeros.
module i2s_dac_tx #(
    parameter int WIDTH     = 16,
    parameter int SLOT_BITS = 32,
    parameter int BCLK_DIV  = 8
) (
    input  logic        CLOCK_50,
    input  logic        RESET,
    i2s_dac_tx_if.slave s_if,
    output logic        FRAME_START,
    output logic        AUD_BCLK,
    output logic        AUD_DACLRCK,
    output logic        AUD_DACDAT,
    output logic [7:0]  UNDERRUN_CNT
);
    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int BIT_W = $clog2(2 * SLOT_BITS);

    localparam logic [DIV_W-1:0] DIV_TC  = DIV_W'(BCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_TC  = BIT_W'(2 * SLOT_BITS - 1);
    localparam logic [BIT_W-1:0] SLOT_B  = BIT_W'(SLOT_BITS);
    localparam logic [BIT_W-1:0] WIDTH_B = BIT_W'(WIDTH);

    logic [DIV_W-1:0] r_div_cnt;
    logic             r_bclk;
    logic [BIT_W-1:0] r_bit_cnt;
    logic             r_lrck;
    logic             r_dat;
    logic             r_frame_start;
    logic             r_full;
    logic             r_first_load;
    logic [WIDTH-1:0] r_buf_l;
    logic [WIDTH-1:0] r_buf_r;
    logic [WIDTH-1:0] r_shift_l;
    logic [WIDTH-1:0] r_shift_r;
    logic [7:0]       r_underrun_cnt;

    logic             w_tick;
    logic             w_fall;
    logic             w_load;
    logic             w_hs;
    logic             w_right_nxt;
    logic             w_data_slot;
    logic [BIT_W-1:0] w_bit_nxt;
    logic [BIT_W-1:0] w_k;
    logic [WIDTH-1:0] w_load_l;
    logic [WIDTH-1:0] w_load_r;
    logic [WIDTH-1:0] w_fill_l;
    logic [WIDTH-1:0] w_fill_r;

    // NOTE: every always_comb output is assigned on every path, so no latches are inferred.
    always_comb begin
        w_tick      = (r_div_cnt == DIV_TC);
        w_fall      = w_tick && r_bclk;
        w_bit_nxt   = (r_bit_cnt == BIT_TC) ? '0 : r_bit_cnt + 1'b1;
        w_load      = w_fall && (r_bit_cnt == BIT_TC);
        w_right_nxt = (w_bit_nxt >= SLOT_B);
        w_k         = w_right_nxt ? (w_bit_nxt - SLOT_B) : w_bit_nxt;
        w_data_slot = (w_k != '0) && (w_k <= WIDTH_B);
        // Load sees the registered full flag, so a same-cycle handshake still counts as an underrun.
        w_hs        = s_if.SAMPLE_VALID && !r_full;
        w_load_l    = r_full ? r_buf_l : w_fill_l;
        w_load_r    = r_full ? r_buf_r : w_fill_r;
    end

`ifdef I2S_TX_HOLD_LAST_EN
    logic [WIDTH-1:0] r_last_l;
    logic [WIDTH-1:0] r_last_r;

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_last_l <= '0;
            r_last_r <= '0;
        end else if (w_load) begin
            r_last_l <= w_load_l;
            r_last_r <= w_load_r;
        end
    end

    assign w_fill_l = r_last_l;
    assign w_fill_r = r_last_r;
`else
    assign w_fill_l = '0;
    assign w_fill_r = '0;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_div_cnt <= '0;
            r_bclk    <= 1'b0;
        end else begin
            r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
            if (w_tick) begin
                r_bclk <= ~r_bclk;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_bit_cnt <= '0;
            r_lrck    <= 1'b0;
            r_dat     <= 1'b0;
            r_shift_l <= '0;
            r_shift_r <= '0;
        end else if (w_fall) begin
            r_bit_cnt <= w_bit_nxt;
            r_lrck    <= w_right_nxt;
            if (w_load) begin
                r_shift_l <= w_load_l;
                r_shift_r <= w_load_r;
                r_dat     <= 1'b0;
            end else if (w_data_slot && w_right_nxt) begin
                r_dat     <= r_shift_r[WIDTH-1];
                r_shift_r <= {r_shift_r[WIDTH-2:0], 1'b0};
            end else if (w_data_slot) begin
                r_dat     <= r_shift_l[WIDTH-1];
                r_shift_l <= {r_shift_l[WIDTH-2:0], 1'b0};
            end else begin
                r_dat     <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_full         <= 1'b0;
            r_buf_l        <= '0;
            r_buf_r        <= '0;
            r_frame_start  <= 1'b0;
            r_first_load   <= 1'b1;
            r_underrun_cnt <= '0;
        end else begin
            r_frame_start <= w_load;
            if (w_hs) begin
                r_buf_l <= s_if.SAMPLE_L;
                r_buf_r <= s_if.SAMPLE_R;
                r_full  <= 1'b1;
            end else if (w_load) begin
                r_full  <= 1'b0;
            end
            if (w_load) begin
                r_first_load <= 1'b0;
                if (!r_full && !r_first_load && (r_underrun_cnt != 8'hFF)) begin
                    r_underrun_cnt <= r_underrun_cnt + 8'd1;
                end
            end
        end
    end

    assign s_if.SAMPLE_READY = !r_full;
    assign FRAME_START       = r_frame_start;
    assign AUD_BCLK          = r_bclk;
    assign AUD_DACLRCK       = r_lrck;
    assign AUD_DACDAT        = r_dat;
    assign UNDERRUN_CNT      = r_underrun_cnt;
endmodule
